uart_sd_cmd_ctrl: RTL

//  UART-to-SD command controller. Parses multi-byte UART commands into card_driver

---
 rtl/uart_sd_cmd_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_sd_cmd_ctrl.sv
// UART command parser for card_driver write/read requests, write-pattern generator and FIFO-to-UART forwarder.
// Define UART_CMD_ACK_EN to send "K" after each completed request and "T" after each abandoned command.
module uart_sd_cmd_ctrl #(
    parameter int         ADDR_W      = 32,
    parameter int         LEN_W       = 8,
    parameter int         TIMEOUT_CYC = 5000000,
    parameter logic [7:0] PAT_INIT    = 8'h41
) (
    input  logic              CLOCK50,
    input  logic              nRESET,
    input  logic              RX_STB,
    input  logic [7:0]        RX_DAT,
    output logic              RX_ACK,
    output logic              TX_STB,
    output logic [7:0]        TX_DAT,
    input  logic              TX_ACK,
    input  logic              TX_RDY,
    output logic              WR_STB,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [LEN_W-1:0]  WR_LENGTH,
    input  logic              WR_ACK,
    output logic              RD_STB,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic [LEN_W-1:0]  RD_LENGTH,
    input  logic              RD_ACK,
    output logic              WD_STB,
    output logic [7:0]        WD_DATA,
    input  logic              WD_ACK,
    input  logic              FF_EMPTY,
    output logic              FF_RDEN,
    input  logic [7:0]        FF_Q,
    output logic              BUSY
);
    localparam int AB = ADDR_W / 8;
    localparam int LB = LEN_W / 8;
    localparam int BW = $clog2(AB + LB + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] C_W = 8'h77, C_R = 8'h72, C_M = 8'h6D, C_S = 8'h73;

    localparam logic [2:0] P_IDLE = 3'd0, P_ADDR = 3'd1, P_LEN = 3'd2,
                           P_ISSUE = 3'd3, P_WAIT = 3'd4, P_MODE = 3'd5;
    localparam logic [1:0] F_IDLE = 2'd0, F_RD = 2'd1, F_CAP = 2'd2, F_SEND = 2'd3;

    logic [2:0]        r_pst;
    logic [1:0]        r_fst;
    logic              r_dir;
    logic [BW-1:0]     r_bcnt;
    logic [TW-1:0]     r_to_cnt;
    logic [ADDR_W-1:0] r_addr_sh;
    logic [LEN_W-1:0]  r_len_sh;
    logic [1:0]        r_mode;
    logic [7:0]        r_pat;
    logic [7:0]        w_pat_nxt;
    logic [7:0]        w_seed;
    logic              w_timed, w_timeout, w_ack_done, w_reseed, w_mode_wr;

    assign RX_ACK = RX_STB;
    assign BUSY   = (r_pst != P_IDLE);
    assign WD_STB = 1'b1;
    assign WD_DATA = r_pat;

    assign w_timed    = (r_pst == P_ADDR) || (r_pst == P_LEN) || (r_pst == P_MODE);
    assign w_timeout  = w_timed && !RX_STB && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_ack_done = (r_pst == P_WAIT) && (r_dir ? RD_ACK : WR_ACK);
    assign w_reseed   = (r_pst == P_IDLE) && RX_STB && (RX_DAT == C_S);
    assign w_mode_wr  = (r_pst == P_MODE) && RX_STB && !w_timeout;

    always_ff @(posedge CLOCK50 or negedge nRESET) begin
        if (!nRESET)                  r_to_cnt <= '0;
        else if (!w_timed || RX_STB)  r_to_cnt <= '0;
        else                          r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_ff @(posedge CLOCK50 or negedge nRESET) begin
        if (!nRESET) begin
            r_pst     <= P_IDLE;
            r_dir     <= 1'b0;
            r_bcnt    <= '0;
            r_addr_sh <= '0;
            r_len_sh  <= '0;
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            WR_ADDR   <= '0;
            WR_LENGTH <= '0;
            RD_ADDR   <= '0;
            RD_LENGTH <= '0;
        end else begin
            WR_STB <= 1'b0;
            RD_STB <= 1'b0;
            case (r_pst)
                P_IDLE: if (RX_STB) begin
                    r_bcnt <= '0;
                    if (RX_DAT == C_W)      begin r_dir <= 1'b0; r_pst <= P_ADDR; end
                    else if (RX_DAT == C_R) begin r_dir <= 1'b1; r_pst <= P_ADDR; end
                    else if (RX_DAT == C_M) r_pst <= P_MODE;
                end
                P_MODE: if (w_timeout || RX_STB) r_pst <= P_IDLE;
                P_ADDR: begin
                    if (w_timeout) r_pst <= P_IDLE;
                    else if (RX_STB) begin
                        r_addr_sh <= (r_addr_sh << 8) | ADDR_W'(RX_DAT);
                        if (r_bcnt == BW'(AB - 1)) begin r_bcnt <= '0; r_pst <= P_LEN; end
                        else r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                P_LEN: begin
                    if (w_timeout) r_pst <= P_IDLE;
                    else if (RX_STB) begin
                        r_len_sh <= (r_len_sh << 8) | LEN_W'(RX_DAT);
                        if (r_bcnt == BW'(LB - 1)) begin r_bcnt <= '0; r_pst <= P_ISSUE; end
                        else r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                P_ISSUE: begin
                    if (r_dir) begin RD_STB <= 1'b1; RD_ADDR <= r_addr_sh; RD_LENGTH <= r_len_sh; end
                    else       begin WR_STB <= 1'b1; WR_ADDR <= r_addr_sh; WR_LENGTH <= r_len_sh; end
                    r_pst <= P_WAIT;
                end
                P_WAIT: if (w_ack_done) r_pst <= P_IDLE;
                default: r_pst <= P_IDLE;
            endcase
        end
    end

    // LFSR and rotate lock up at zero, so a zero seed is replaced in those modes
    assign w_seed = (PAT_INIT == 8'h00 && r_mode[1]) ? 8'h01 : PAT_INIT;

    always_comb begin
        w_pat_nxt = r_pat;
        case (r_mode)
            2'd0:    w_pat_nxt = r_pat + 8'd1;
            2'd1:    w_pat_nxt = r_pat;
            2'd2:    w_pat_nxt = {r_pat[6:0], r_pat[7] ^ r_pat[5] ^ r_pat[4] ^ r_pat[3]};
            default: w_pat_nxt = {r_pat[6:0], r_pat[7]};
        endcase
    end

    always_ff @(posedge CLOCK50 or negedge nRESET) begin
        if (!nRESET) begin
            r_pat  <= PAT_INIT;
            r_mode <= 2'd0;
        end else begin
            if (w_reseed)    r_pat <= w_seed;
            else if (WD_ACK) r_pat <= w_pat_nxt;
            if (w_mode_wr)   r_mode <= RX_DAT[1:0];
        end
    end

`ifdef UART_CMD_ACK_EN
    logic r_pend_k, r_pend_t;
`endif

    always_ff @(posedge CLOCK50 or negedge nRESET) begin
        if (!nRESET) begin
            r_fst   <= F_IDLE;
            FF_RDEN <= 1'b0;
            TX_STB  <= 1'b0;
            TX_DAT  <= 8'h00;
`ifdef UART_CMD_ACK_EN
            r_pend_k <= 1'b0;
            r_pend_t <= 1'b0;
`endif
        end else begin
            case (r_fst)
                F_IDLE: begin
`ifdef UART_CMD_ACK_EN
                    if (r_pend_k || r_pend_t) begin
                        TX_DAT <= r_pend_k ? 8'h4B : 8'h54;
                        TX_STB <= 1'b1;
                        if (r_pend_k) r_pend_k <= 1'b0;
                        else          r_pend_t <= 1'b0;
                        r_fst <= F_SEND;
                    end else
`endif
                    if (!FF_EMPTY && TX_RDY) begin
                        FF_RDEN <= 1'b1;
                        r_fst   <= F_RD;
                    end
                end
                F_RD: begin
                    FF_RDEN <= 1'b0;
                    r_fst   <= F_CAP;
                end
                F_CAP: begin
                    TX_DAT <= FF_Q;
                    TX_STB <= 1'b1;
                    r_fst  <= F_SEND;
                end
                default: if (TX_ACK) begin
                    TX_STB <= 1'b0;
                    r_fst  <= F_IDLE;
                end
            endcase
`ifdef UART_CMD_ACK_EN
            // a new event in the same cycle as its send keeps the flag set
            if (w_ack_done) r_pend_k <= 1'b1;
            if (w_timeout)  r_pend_t <= 1'b1;
`endif
        end
    end

endmodule
